// File: rtl/bsg_fpu_clz_norm_pipe.sv
// bsg_fpu_clz_norm_pipe
//
// Two-stage pipelined leading-zero / leading-sign counter and normaliser.
// Stage 1 captures the operand together with its count. Stage 2 left-shifts
// the operand by that count and holds the result until the consumer takes it.
//
// Ports
//   clk_i       clock
//   reset_n_i   asynchronous active-low reset
//   v_i         operand valid
//   data_i      operand (width_p bits)
//   mode_i      0 = count leading zeros, 1 = count redundant sign bits
//   ready_o     operand can be accepted this cycle (combinational from yumi_i)
//   v_o         result valid
//   count_o     leading zero / redundant sign count (0..width_p)
//   data_o      operand << count_o, zero-filled, truncated to width_p
//   zero_o      operand was all zeros (mode independent)
//   yumi_i      consumer takes the result this cycle (only while v_o = 1)
module bsg_fpu_clz_norm_pipe #(
    parameter int width_p = 16,
    localparam int lg_cnt_lp = $clog2(width_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    input  logic [width_p-1:0]   data_i,
    input  logic                 mode_i,
    output logic                 ready_o,
    output logic                 v_o,
    output logic [lg_cnt_lp-1:0] count_o,
    output logic [width_p-1:0]   data_o,
    output logic                 zero_o,
    input  logic                 yumi_i
);

    // ------------------------------------------------------------------
    // Count logic (operates directly on the incoming operand)
    // ------------------------------------------------------------------

    // sign_diff[i] is set where bit i differs from bit i+1; the highest such
    // position marks the end of the run of bits equal to the MSB.
    logic [width_p-2:0] sign_diff;

    for (genvar gi = 0; gi < width_p - 1; gi++) begin : g_sign_diff
        assign sign_diff[gi] = data_i[gi] ^ data_i[gi+1];
    end

    logic [lg_cnt_lp-1:0] clz_cnt;
    logic [lg_cnt_lp-1:0] cls_cnt;
    logic [lg_cnt_lp-1:0] cnt_next;

    // Ascending scan: the last (highest) set bit found wins, which is the
    // priority encode of the MSB-first view of the vector.
    always_comb begin
        clz_cnt = lg_cnt_lp'(width_p);
        for (int i = 0; i < width_p; i++) begin
            if (data_i[i]) begin
                clz_cnt = lg_cnt_lp'(width_p - 1 - i);
            end
        end
    end

    always_comb begin
        cls_cnt = lg_cnt_lp'(width_p - 1);
        for (int i = 0; i < width_p - 1; i++) begin
            if (sign_diff[i]) begin
                cls_cnt = lg_cnt_lp'(width_p - 2 - i);
            end
        end
    end

    assign cnt_next = mode_i ? cls_cnt : clz_cnt;

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic                 s1_v_reg;
    logic [width_p-1:0]   s1_data_reg;
    logic [lg_cnt_lp-1:0] s1_cnt_reg;

    logic                 s2_v_reg;
    logic [width_p-1:0]   s2_data_reg;
    logic [lg_cnt_lp-1:0] s2_cnt_reg;
    logic                 s2_zero_reg;

    logic s2_en;
    logic in_xfer;

    // S2 can take new contents when it is empty or its result is being taken.
    assign s2_en   = ~s2_v_reg | yumi_i;
    // S1 can load when it is empty or it is moving into S2 this cycle.
    assign ready_o = ~s1_v_reg | s2_en;
    assign in_xfer = v_i & ready_o;

    // ------------------------------------------------------------------
    // Stage 1: operand + count
    // ------------------------------------------------------------------
    // The mode only influences the count, so it is not carried further.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_reg    <= 1'b0;
            s1_data_reg <= '0;
            s1_cnt_reg  <= '0;
        end else if (in_xfer) begin
            s1_v_reg    <= 1'b1;
            s1_data_reg <= data_i;
            s1_cnt_reg  <= cnt_next;
        end else if (s2_en) begin
            s1_v_reg    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise and hold result
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_v_reg    <= 1'b0;
            s2_data_reg <= '0;
            s2_cnt_reg  <= '0;
            s2_zero_reg <= 1'b0;
        end else if (s2_en) begin
            // An empty S1 turns into a bubble; data registers keep their value.
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                // A shift by width_p (CLZ of zero) naturally yields zero.
                s2_data_reg <= s1_data_reg << s1_cnt_reg;
                s2_cnt_reg  <= s1_cnt_reg;
                s2_zero_reg <= ~|s1_data_reg;
            end
        end
    end

    assign v_o     = s2_v_reg;
    assign data_o  = s2_data_reg;
    assign count_o = s2_cnt_reg;
    assign zero_o  = s2_zero_reg;

endmodule

// File: tb/tb_bsg_fpu_clz_norm_pipe.sv
// Testbench for bsg_fpu_clz_norm_pipe: directed vectors on a 16-bit and a
// 5-bit instance, backpressure ordering, asynchronous reset with both stages
// full, and a random stream against a behavioural reference model.
module tb_bsg_fpu_clz_norm_pipe;

    logic clk;
    logic reset_n;

    // 16-bit instance
    logic        v16, m16, yumi16, ready16, vo16, z16;
    logic [15:0] d16, do16;
    logic [4:0]  cnt16;

    // 5-bit instance
    logic        v5, m5, yumi5, ready5, vo5, z5;
    logic [4:0]  d5, do5;
    logic [2:0]  cnt5;

    int checks = 0;
    int errors = 0;

    bsg_fpu_clz_norm_pipe #(.width_p(16)) dut16 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v16), .data_i(d16), .mode_i(m16),
        .ready_o(ready16), .v_o(vo16), .count_o(cnt16), .data_o(do16),
        .zero_o(z16), .yumi_i(yumi16)
    );

    bsg_fpu_clz_norm_pipe #(.width_p(5)) dut5 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v5), .data_i(d5), .mode_i(m5),
        .ready_o(ready5), .v_o(vo5), .count_o(cnt5), .data_o(do5),
        .zero_o(z5), .yumi_i(yumi5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        m;
    } item_t;
    item_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk bits from the MSB downward.
    function automatic int ref_cnt(input logic [15:0] d, input logic m);
        int n = 0;
        if (!m) begin
            for (int i = 15; i >= 0; i--) begin
                if (d[i]) break;
                n++;
            end
        end else begin
            for (int i = 14; i >= 0; i--) begin
                if (d[i] != d[15]) break;
                n++;
            end
        end
        return n;
    endfunction

    // One operand through an empty pipe: no result after 1 cycle, result after 2.
    task automatic run16(input string tag, input logic [15:0] d, input logic m,
                         input int ec, input logic [15:0] ed, input logic ez);
        v16 = 1'b1; d16 = d; m16 = m; yumi16 = 1'b0;
        #1 chk({tag, "_ready"}, 32'(ready16), 32'd1);
        tick();
        v16 = 1'b0;
        chk({tag, "_lat1_v"}, 32'(vo16), 32'd0);
        tick();
        chk({tag, "_v"},     32'(vo16),  32'd1);
        chk({tag, "_count"}, 32'(cnt16), 32'(ec));
        chk({tag, "_data"},  32'(do16),  32'(ed));
        chk({tag, "_zero"},  32'(z16),   32'(ez));
        $display("w16 %s: data_i=%h mode=%0d -> count=%0d data_o=%h zero=%0d",
                 tag, d, m, cnt16, do16, z16);
        yumi16 = 1'b1;
        tick();
        yumi16 = 1'b0;
        chk({tag, "_drained"}, 32'(vo16), 32'd0);
    endtask

    task automatic run5(input string tag, input logic [4:0] d, input logic m,
                        input int ec, input logic [4:0] ed, input logic ez);
        v5 = 1'b1; d5 = d; m5 = m; yumi5 = 1'b0;
        tick();
        v5 = 1'b0;
        tick();
        chk({tag, "_v"},     32'(vo5),  32'd1);
        chk({tag, "_count"}, 32'(cnt5), 32'(ec));
        chk({tag, "_data"},  32'(do5),  32'(ed));
        chk({tag, "_zero"},  32'(z5),   32'(ez));
        $display("w5 %s: data_i=%b mode=%0d -> count=%0d data_o=%b zero=%0d",
                 tag, d, m, cnt5, do5, z5);
        yumi5 = 1'b1;
        tick();
        yumi5 = 1'b0;
    endtask

    // yumi without a valid result is a protocol violation.
    always @(negedge clk) begin
        if (reset_n && ((yumi16 && !vo16) || (yumi5 && !vo5))) begin
            errors++;
            $error("FAIL yumi_protocol: yumi asserted with v_o=0");
        end
    end

    initial begin
        item_t it;
        int    ec;
        logic [15:0] ed;

        reset_n = 1'b0;
        v16 = 1'b0; d16 = '0; m16 = 1'b0; yumi16 = 1'b0;
        v5 = 1'b0;  d5 = '0;  m5 = 1'b0;  yumi5 = 1'b0;

        #3;
        chk("rst_v",     32'(vo16),    32'd0);
        chk("rst_ready", 32'(ready16), 32'd1);
        chk("rst_count", 32'(cnt16),   32'd0);
        chk("rst_data",  32'(do16),    32'd0);
        chk("rst_zero",  32'(z16),     32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Directed 16-bit vectors
        run16("clz_0001", 16'h0001, 1'b0, 15, 16'h8000, 1'b0);
        run16("clz_0000", 16'h0000, 1'b0, 16, 16'h0000, 1'b1);
        run16("cls_0000", 16'h0000, 1'b1, 15, 16'h0000, 1'b1);
        run16("cls_ff00", 16'hFF00, 1'b1, 7,  16'h8000, 1'b0);
        run16("cls_0f00", 16'h0F00, 1'b1, 3,  16'h7800, 1'b0);
        run16("cls_ffff", 16'hFFFF, 1'b1, 15, 16'h8000, 1'b0);
        run16("clz_8000", 16'h8000, 1'b0, 0,  16'h8000, 1'b0);
        run16("cls_8000", 16'h8000, 1'b1, 0,  16'h8000, 1'b0);
        run16("clz_0350", 16'h0350, 1'b0, 6,  16'hD400, 1'b0);

        // Directed 5-bit vectors
        run5("w5_clz_00100", 5'b00100, 1'b0, 2, 5'b10000, 1'b0);
        run5("w5_clz_00000", 5'b00000, 1'b0, 5, 5'b00000, 1'b1);
        run5("w5_cls_11111", 5'b11111, 1'b1, 4, 5'b10000, 1'b0);
        run5("w5_cls_00011", 5'b00011, 1'b1, 2, 5'b01100, 1'b0);

        // Backpressure: three back-to-back operands with yumi held low
        m16 = 1'b0; yumi16 = 1'b0;
        v16 = 1'b1; d16 = 16'h0100;
        #1 chk("bp_ready_a", 32'(ready16), 32'd1);
        tick();
        d16 = 16'h0010;
        #1 chk("bp_ready_b", 32'(ready16), 32'd1);
        tick();
        d16 = 16'h0001;
        #1 chk("bp_ready_c_stall", 32'(ready16), 32'd0);
        chk("bp_v_a",     32'(vo16),  32'd1);
        chk("bp_count_a", 32'(cnt16), 32'd7);
        tick();
        chk("bp_hold_ready", 32'(ready16), 32'd0);
        chk("bp_hold_count", 32'(cnt16),   32'd7);
        chk("bp_hold_data",  32'(do16),    32'h8000);
        yumi16 = 1'b1;
        #1 chk("bp_ready_release", 32'(ready16), 32'd1);
        $display("bp out: count=%0d data_o=%h", cnt16, do16);
        tick();
        v16 = 1'b0;
        chk("bp_v_b",     32'(vo16),  32'd1);
        chk("bp_count_b", 32'(cnt16), 32'd11);
        $display("bp out: count=%0d data_o=%h", cnt16, do16);
        tick();
        chk("bp_v_c",     32'(vo16),  32'd1);
        chk("bp_count_c", 32'(cnt16), 32'd15);
        $display("bp out: count=%0d data_o=%h", cnt16, do16);
        tick();
        yumi16 = 1'b0;
        chk("bp_empty", 32'(vo16), 32'd0);

        // Asynchronous reset with both stages full
        v16 = 1'b1; d16 = 16'h00F0;
        tick();
        d16 = 16'h0F00;
        tick();
        v16 = 1'b0;
        chk("arst_full_ready", 32'(ready16), 32'd0);
        chk("arst_full_v",     32'(vo16),    32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_v",     32'(vo16),    32'd0);
        chk("arst_ready", 32'(ready16), 32'd1);
        chk("arst_count", 32'(cnt16),   32'd0);
        chk("arst_data",  32'(do16),    32'd0);
        $display("async reset: v_o=%0d ready_o=%0d", vo16, ready16);
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_post_v", 32'(vo16), 32'd0);
        run16("post_rst_8000", 16'h8000, 1'b0, 0, 16'h8000, 1'b0);

        // Random stream with random valid / yumi against the model
        for (int c = 0; c < 420; c++) begin
            tick();
            yumi16 = vo16 & ($urandom_range(0, 3) != 0);
            v16    = (c < 380) ? 1'($urandom_range(0, 1)) : 1'b0;
            d16    = 16'($urandom) >> $urandom_range(0, 16);
            if ($urandom_range(0, 7) == 0) d16 = ~d16;
            m16    = 1'($urandom_range(0, 1));
            #1;
            if (vo16 && yumi16) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_output", 32'(q.size()), 32'd1);
                end else begin
                    it = q.pop_front();
                    ec = ref_cnt(it.d, it.m);
                    ed = it.d << ec;
                    chk("rand_count", 32'(cnt16), 32'(ec));
                    chk("rand_data",  32'(do16),  32'(ed));
                    chk("rand_zero",  32'(z16),   32'(it.d == 16'h0000));
                    $display("rand: data_i=%h mode=%0d -> count=%0d data_o=%h zero=%0d",
                             it.d, it.m, cnt16, do16, z16);
                end
            end
            if (v16 && ready16) q.push_back('{d: d16, m: m16});
        end
        yumi16 = 1'b0;
        v16 = 1'b0;
        chk("rand_all_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
